// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matmul engine: controller states,
// output saturation helpers and lane slicing.
`default_nettype none

package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SHIFT = 2'd3
    } state_t;

    // Working width for saturation, wide enough for any accumulator in use.
    localparam int SAT_W = 128;

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

    function automatic logic [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                  input int dw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi        = '0;
        hi[dw-1]  = 1'b1;
        hi        = hi - 1;
        lo        = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic sat_clamps(input logic signed [SAT_W-1:0] v,
                                        input int dw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi        = '0;
        hi[dw-1]  = 1'b1;
        hi        = hi - 1;
        lo        = ~hi;
        return (v > hi) || (v < lo);
    endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_pe.sv
// One output-stationary MAC cell: forwards operands right/down with one
// register of latency and can clear or circularly load its accumulator.
`default_nettype none

module systolic_pe #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        clear,
    input  logic                        shift,
    input  logic [DATA_WIDTH-1:0]       act_in,
    input  logic                        act_in_valid,
    input  logic [DATA_WIDTH-1:0]       wgt_in,
    input  logic                        wgt_in_valid,
    input  logic signed [ACC_WIDTH-1:0] shift_in,
    output logic [DATA_WIDTH-1:0]       act_out,
    output logic                        act_out_valid,
    output logic [DATA_WIDTH-1:0]       wgt_out,
    output logic                        wgt_out_valid,
    output logic signed [ACC_WIDTH-1:0] acc
);

    logic signed [2*DATA_WIDTH-1:0] act_ext;
    logic signed [2*DATA_WIDTH-1:0] wgt_ext;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]    product_ext;

    assign act_ext     = {{DATA_WIDTH{act_in[DATA_WIDTH-1]}}, act_in};
    assign wgt_ext     = {{DATA_WIDTH{wgt_in[DATA_WIDTH-1]}}, wgt_in};
    assign product     = act_ext * wgt_ext;
    assign product_ext = {{(ACC_WIDTH-2*DATA_WIDTH){product[2*DATA_WIDTH-1]}}, product};

    always_ff @(posedge clk) begin
        if (rst) begin
            act_out       <= '0;
            act_out_valid <= 1'b0;
            wgt_out       <= '0;
            wgt_out_valid <= 1'b0;
            acc           <= '0;
        end else begin
            if (enable) begin
                act_out       <= act_in;
                act_out_valid <= act_in_valid;
                wgt_out       <= wgt_in;
                wgt_out_valid <= wgt_in_valid;
            end
            if (clear)
                acc <= '0;
            else if (shift)
                acc <= shift_in;
            else if (enable && act_in_valid && wgt_in_valid)
                acc <= acc + product_ext;
        end
    end

endmodule

`default_nettype wire

// File: rtl/systolic_matmul_engine.sv
// Output-stationary systolic matrix multiply: skewed operand feed, PE grid,
// and a circular-shift readout that leaves accumulators intact.
`default_nettype none

module systolic_matmul_engine
    import systolic_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int K_WIDTH    = 20,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ctrl_valid,
    output logic                       ctrl_ready,
    input  logic [K_WIDTH-1:0]         ctrl_k,
    input  logic                       ctrl_accumulate,
    input  logic [ROWS*DATA_WIDTH-1:0] act_in,
    input  logic                       act_valid,
    output logic                       act_ready,
    input  logic [COLS*DATA_WIDTH-1:0] wgt_in,
    input  logic                       wgt_valid,
    output logic                       wgt_ready,
    output logic [ROWS*DATA_WIDTH-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       sat_flag
);

    localparam int                 BEAT_W     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(COLS-1);
    localparam logic [K_WIDTH-1:0] DRAIN_LAST = K_WIDTH'(ROWS+COLS-2);

    state_t               state;
    state_t               state_next;
    logic [K_WIDTH-1:0]   cnt;
    logic [BEAT_W-1:0]    beat;
    logic                 feeding;
    logic                 hs;
    logic                 step;
    logic                 clear_acc;
    logic                 shift_acc;
    logic [ROWS-1:0]      lane_sat;

    assign feeding = (state == ST_FEED);
    assign hs      = feeding && act_valid && wgt_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Outputs are forced inactive while rst is high so an abort never shows a beat.
    always_comb begin
        state_next = state;
        ctrl_ready = 1'b0;
        act_ready  = 1'b0;
        wgt_ready  = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        step       = 1'b0;
        clear_acc  = 1'b0;
        shift_acc  = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    ctrl_ready = 1'b1;
                    if (ctrl_valid) begin
                        clear_acc  = !ctrl_accumulate;
                        state_next = (ctrl_k == '0) ? ST_SHIFT : ST_FEED;
                    end
                end
                ST_FEED: begin
                    act_ready = hs;
                    wgt_ready = hs;
                    step      = hs;
                    if (hs && cnt == K_WIDTH'(1)) state_next = ST_DRAIN;
                end
                ST_DRAIN: begin
                    step = 1'b1;
                    if (cnt == '0) state_next = ST_SHIFT;
                end
                ST_SHIFT: begin
                    out_valid = 1'b1;
                    out_last  = (beat == LAST_BEAT);
                    if (out_ready) begin
                        shift_acc = 1'b1;
                        if (beat == LAST_BEAT) state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            beat     <= '0;
            sat_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (ctrl_valid) begin
                    cnt      <= ctrl_k;
                    beat     <= '0;
                    sat_flag <= 1'b0;
                end
                ST_FEED: if (hs) cnt <= (cnt == K_WIDTH'(1)) ? DRAIN_LAST : cnt - K_WIDTH'(1);
                ST_DRAIN: if (cnt != '0) cnt <= cnt - K_WIDTH'(1);
                ST_SHIFT: if (out_ready) begin
                    beat <= beat + BEAT_W'(1);
                    if (|lane_sat) sat_flag <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic [DATA_WIDTH-1:0] act_sk   [ROWS];
    logic                  act_sk_v [ROWS];
    logic [DATA_WIDTH-1:0] wgt_sk   [COLS];
    logic                  wgt_sk_v [COLS];

    // Lane r is delayed r steps; drain cycles push zero, invalid bubbles.
    for (genvar r = 0; r < ROWS; r++) begin : g_act_skew
        logic [DATA_WIDTH-1:0] lane_d;
        assign lane_d = feeding ? act_in[lane_lo(r, DATA_WIDTH) +: DATA_WIDTH] : '0;
        if (r == 0) begin : g_pass
            assign act_sk[r]   = lane_d;
            assign act_sk_v[r] = feeding;
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] sr  [r];
            logic                  srv [r];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < r; i++) begin
                        sr[i]  <= '0;
                        srv[i] <= 1'b0;
                    end
                end else if (step) begin
                    sr[0]  <= lane_d;
                    srv[0] <= feeding;
                    for (int i = 1; i < r; i++) begin
                        sr[i]  <= sr[i-1];
                        srv[i] <= srv[i-1];
                    end
                end
            end
            assign act_sk[r]   = sr[r-1];
            assign act_sk_v[r] = srv[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_wgt_skew
        logic [DATA_WIDTH-1:0] lane_d;
        assign lane_d = feeding ? wgt_in[lane_lo(c, DATA_WIDTH) +: DATA_WIDTH] : '0;
        if (c == 0) begin : g_pass
            assign wgt_sk[c]   = lane_d;
            assign wgt_sk_v[c] = feeding;
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] sr  [c];
            logic                  srv [c];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < c; i++) begin
                        sr[i]  <= '0;
                        srv[i] <= 1'b0;
                    end
                end else if (step) begin
                    sr[0]  <= lane_d;
                    srv[0] <= feeding;
                    for (int i = 1; i < c; i++) begin
                        sr[i]  <= sr[i-1];
                        srv[i] <= srv[i-1];
                    end
                end
            end
            assign wgt_sk[c]   = sr[c-1];
            assign wgt_sk_v[c] = srv[c-1];
        end
    end

    logic [DATA_WIDTH-1:0]       act_fwd   [ROWS][COLS];
    logic                        act_fwd_v [ROWS][COLS];
    logic [DATA_WIDTH-1:0]       wgt_fwd   [ROWS][COLS];
    logic                        wgt_fwd_v [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0] acc       [ROWS][COLS];
    logic [ROWS-1:0]             edge_unused_act;
    logic [COLS-1:0]             edge_unused_wgt;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign edge_unused_act[r] = ^{act_fwd[r][COLS-1], act_fwd_v[r][COLS-1]};
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [DATA_WIDTH-1:0] a_in;
            logic                  a_v;
            logic [DATA_WIDTH-1:0] w_in;
            logic                  w_v;
            if (c == 0) begin : g_a_edge
                assign a_in = act_sk[r];
                assign a_v  = act_sk_v[r];
            end else begin : g_a_int
                assign a_in = act_fwd[r][c-1];
                assign a_v  = act_fwd_v[r][c-1];
            end
            if (r == 0) begin : g_w_edge
                assign w_in = wgt_sk[c];
                assign w_v  = wgt_sk_v[c];
            end else begin : g_w_int
                assign w_in = wgt_fwd[r-1][c];
                assign w_v  = wgt_fwd_v[r-1][c];
            end
            systolic_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk           (clk),
                .rst           (rst),
                .enable        (step),
                .clear         (clear_acc),
                .shift         (shift_acc),
                .act_in        (a_in),
                .act_in_valid  (a_v),
                .wgt_in        (w_in),
                .wgt_in_valid  (w_v),
                .shift_in      (acc[r][(c+1)%COLS]),
                .act_out       (act_fwd[r][c]),
                .act_out_valid (act_fwd_v[r][c]),
                .wgt_out       (wgt_fwd[r][c]),
                .wgt_out_valid (wgt_fwd_v[r][c]),
                .acc           (acc[r][c])
            );
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_wgt_edge
        assign edge_unused_wgt[c] = ^{wgt_fwd[ROWS-1][c], wgt_fwd_v[ROWS-1][c]};
    end

    // Column 0 always holds the current beat; rotation brings the next one in.
    for (genvar r = 0; r < ROWS; r++) begin : g_out
        logic signed [ACC_WIDTH-1:0]  scaled;
        logic signed [SAT_W-1:0]      wide;
        logic [SAT_W-DATA_WIDTH-1:0]  clamp_hi_unused;
        assign scaled = acc[r][0] >>> FRAC_BITS;
        assign wide   = {{(SAT_W-ACC_WIDTH){scaled[ACC_WIDTH-1]}}, scaled};
        assign {clamp_hi_unused, out_data[lane_lo(r, DATA_WIDTH) +: DATA_WIDTH]} =
            saturate(wide, DATA_WIDTH);
        assign lane_sat[r] = sat_clamps(wide, DATA_WIDTH);
    end

endmodule

`default_nettype wire

// File: tb/tb_systolic_matmul_engine.sv
// Directed + randomized bench for systolic_matmul_engine (4x4, Q8.8) against
// a plain matrix-product reference model.
`default_nettype none

module tb_systolic_matmul_engine;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int DW = 16;
    localparam int KW = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic            ctrl_valid;
    logic            ctrl_ready;
    logic [KW-1:0]   ctrl_k;
    logic            ctrl_accumulate;
    logic [R*DW-1:0] act_in;
    logic            act_valid;
    logic            act_ready;
    logic [C*DW-1:0] wgt_in;
    logic            wgt_valid;
    logic            wgt_ready;
    logic [R*DW-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            sat_flag;

    always #5 clk = ~clk;

    systolic_matmul_engine #(
        .ROWS(R), .COLS(C), .DATA_WIDTH(DW), .FRAC_BITS(8), .K_WIDTH(KW), .ACC_WIDTH(2*DW+8)
    ) dut (
        .clk(clk), .rst(rst),
        .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_k(ctrl_k),
        .ctrl_accumulate(ctrl_accumulate),
        .act_in(act_in), .act_valid(act_valid), .act_ready(act_ready),
        .wgt_in(wgt_in), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .sat_flag(sat_flag)
    );

    int      passes = 0;
    int      checks = 0;
    int      fails  = 0;
    longint  macc [R][C];
    shortint amat [R][64];
    shortint wmat [64][C];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Q8.8 result of a 40-bit wrapping accumulator, clamped to 16 bits.
    function automatic longint scaled_of(input longint a);
        longint w;
        w = (a <<< 24) >>> 24;
        return w >>> 8;
    endfunction

    function automatic logic [15:0] exp_lane(input longint a);
        longint s;
        s = scaled_of(a);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    function automatic bit exp_clamp(input longint a);
        longint s;
        s = scaled_of(a);
        return (s > 32767) || (s < -32768);
    endfunction

    task automatic set_identity_part(input int off, input int k);
        for (int i = 0; i < k; i++) begin
            for (int r = 0; r < R; r++) amat[r][i] = (r == i + off) ? 16'sh0100 : 16'sh0;
            for (int c = 0; c < C; c++) wmat[i][c] = shortint'(((i + off) * 4 + c) * 256);
        end
    endtask

    task automatic set_const(input shortint a, input shortint w, input int k);
        for (int i = 0; i < k; i++) begin
            for (int r = 0; r < R; r++) amat[r][i] = a;
            for (int c = 0; c < C; c++) wmat[i][c] = w;
        end
    endtask

    task automatic set_random(input int k);
        for (int i = 0; i < k; i++) begin
            for (int r = 0; r < R; r++) amat[r][i] = shortint'($urandom);
            for (int c = 0; c < C; c++) wmat[i][c] = shortint'($urandom);
        end
    endtask

    task automatic start_run(input int k, input bit accum);
        int guard = 0;
        while (!ctrl_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("start_ready", 64'(ctrl_ready), 64'd1);
        ctrl_valid      = 1'b1;
        ctrl_k          = KW'(k);
        ctrl_accumulate = accum;
        @(negedge clk);
        ctrl_valid = 1'b0;
        if (!accum)
            for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) macc[r][c] = 0;
        for (int i = 0; i < k; i++)
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    macc[r][c] += longint'(amat[r][i]) * longint'(wmat[i][c]);
    endtask

    task automatic feed(input int k, input bit rnd);
        int i = 0;
        int guard = 0;
        bit av;
        bit wv;
        while (i < k && guard < 1000) begin
            for (int r = 0; r < R; r++) act_in[r*DW +: DW] = amat[r][i];
            for (int c = 0; c < C; c++) wgt_in[c*DW +: DW] = wmat[i][c];
            av = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            wv = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            act_valid = av;
            wgt_valid = wv;
            #1;
            check("feed_ready", 64'({act_ready, wgt_ready}), 64'({av & wv, av & wv}));
            if (av && wv) i++;
            @(negedge clk);
            guard++;
        end
        act_valid = 1'b0;
        wgt_valid = 1'b0;
        check("feed_count", 64'(i), 64'(k));
    endtask

    task automatic collect(input int stall_beat);
        int guard = 0;
        bit exp_sat = 1'b0;
        logic [63:0] e;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("out_valid_seen", 64'(out_valid), 64'd1);
        for (int b = 0; b < C; b++) begin
            for (int r = 0; r < R; r++) begin
                e[r*DW +: DW] = exp_lane(macc[r][b]);
                if (exp_clamp(macc[r][b])) exp_sat = 1'b1;
            end
            if (b == stall_beat) begin
                out_ready = 1'b0;
                repeat (3) begin
                    #1;
                    check("stall_data", out_data, e);
                    @(negedge clk);
                end
            end
            out_ready = 1'b1;
            #1;
            check("beat_valid", 64'(out_valid), 64'd1);
            check("beat_data", out_data, e);
            check("beat_last", 64'(out_last), 64'(b == C - 1));
            @(negedge clk);
        end
        out_ready = 1'b0;
        #1;
        check("sat_flag", 64'(sat_flag), 64'(exp_sat));
        check("back_idle", 64'({ctrl_ready, out_valid}), 64'b10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ctrl_valid = 1'b0; ctrl_k = '0; ctrl_accumulate = 1'b0;
        act_in = '0; act_valid = 1'b0; wgt_in = '0; wgt_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ctrl_ready", 64'(ctrl_ready), 64'd1);
        check("rst_outputs", 64'({out_valid, out_last, sat_flag, act_ready, wgt_ready}), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        act_valid = 1'b1; wgt_valid = 1'b1;
        #1;
        check("idle_no_ready", 64'({act_ready, wgt_ready}), 64'd0);
        act_valid = 1'b0; wgt_valid = 1'b0;
        @(negedge clk);

        // Identity activations reproduce the weight matrix.
        set_identity_part(0, 4);
        start_run(4, 1'b0); feed(4, 1'b0); collect(-1);

        // Same data with random valids and a 3-cycle stall on beat 1.
        start_run(4, 1'b0); feed(4, 1'b1); collect(1);

        // Two K=2 tiles chained with accumulate equal the K=4 result.
        set_identity_part(0, 2);
        start_run(2, 1'b0); feed(2, 1'b0); collect(-1);
        set_identity_part(2, 2);
        start_run(2, 1'b1); feed(2, 1'b1); collect(-1);

        // Random full-range operands, then a random accumulated tile.
        set_random(5);
        start_run(5, 1'b0); feed(5, 1'b1); collect(2);
        set_random(3);
        start_run(3, 1'b1); feed(3, 1'b0); collect(-1);

        // Saturation in both directions.
        set_const(16'sh7F00, 16'sh7F00, 2);
        start_run(2, 1'b0); feed(2, 1'b0); collect(-1);
        set_const(-16'sh7F00, 16'sh7F00, 2);
        start_run(2, 1'b0); feed(2, 1'b0); collect(-1);

        // k=0 with clear: straight to readout of zeros.
        start_run(0, 1'b0); collect(-1);

        // Abort during DRAIN, then a K=1 accumulate run must see no residue.
        set_random(1);
        start_run(1, 1'b0); feed(1, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ctrl_ready", 64'(ctrl_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) macc[r][c] = 0;
        @(negedge clk);
        set_random(1);
        start_run(1, 1'b1); feed(1, 1'b0); collect(-1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
